// File: rtl/fir_ctrl.sv
// fir_ctrl: paces samples into a transposed-form FIR datapath, registers its result,
// and manages a shadow/active coefficient bank with an atomic, in-flight-safe commit.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   run               : enable sample processing
//   s_valid/s_ready/s_data : input sample handshake
//   m_valid/m_ready/m_data : registered output sample handshake
//   fir_en, fir_clr, fir_in : datapath advance strobe, history clear, sample
//   fir_out           : datapath result (combinational from fir_in and its registers)
//   coef_flat         : active bank, tap i at [i*BIT_PREC +: BIT_PREC]
//   cfg_we/cfg_addr/cfg_data : shadow bank write port
//   cfg_commit, cfg_busy     : shadow->active swap request / swap in progress
//
// Build option: define FIR_CTRL_SAT_EN to saturate the shifted result into the
// signed OUT_W range; otherwise the result wraps to its low OUT_W bits.

module fir_ctrl #(
    parameter int TAPS     = 8,
    parameter int BIT_PREC = 12,
    parameter int DIV      = 4,
    parameter int SHIFT    = 0,
    parameter int OUT_W    = 2*BIT_PREC+TAPS-1,
    localparam int ACC_W   = 2*BIT_PREC+TAPS-1,
    localparam int AW      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BIT_PREC-1:0]      s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     fir_en,
    output logic                     fir_clr,
    output logic [BIT_PREC-1:0]      fir_in,
    input  logic [ACC_W-1:0]         fir_out,
    output logic [TAPS*BIT_PREC-1:0] coef_flat,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [BIT_PREC-1:0]      cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_busy
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(DIV-1);
    localparam int EW = (OUT_W > ACC_W) ? OUT_W : ACC_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SWAP
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [TW-1:0]              r_tick;
    logic                       r_pending;
    logic                       r_mvalid;
    logic [OUT_W-1:0]           r_mdata;
    logic [BIT_PREC-1:0]        r_shadow [TAPS];
    logic [TAPS*BIT_PREC-1:0]   r_active;

    logic                       w_rdy;
    logic                       w_clr;
    logic                       w_busy;
    logic                       w_fir_en;
    logic                       w_we_ok;
    logic signed [ACC_W-1:0]    w_sh;
    logic signed [EW-1:0]       w_ext;
    logic [OUT_W-1:0]           w_res;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs
    always_comb begin
        w_next = r_state;
        w_rdy  = 1'b0;
        w_clr  = 1'b0;
        w_busy = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending) w_next = S_SWAP;
                else if (run)  w_next = S_RUN;
            end
            S_RUN: begin
                // Leave only once the held output has drained
                if (!r_mvalid) begin
                    if (r_pending) w_next = S_SWAP;
                    else if (!run) w_next = S_IDLE;
                end
                w_rdy = run & ~r_pending & (r_tick == TMAX)
                      & (~r_mvalid | m_ready);
            end
            S_SWAP: begin
                w_next = run ? S_RUN : S_IDLE;
                w_clr  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        w_busy = r_pending | (r_state == S_SWAP);
        if (rst) begin
            w_rdy  = 1'b0;
            w_clr  = 1'b0;
            w_busy = 1'b0;
        end
    end

    assign w_fir_en = s_valid & w_rdy;
    assign w_we_ok  = cfg_we & ~r_pending & (r_state != S_SWAP)
                    & (32'(cfg_addr) < TAPS);

    // Result scaling: shift, sign-extend to a common width, then reduce
    assign w_sh  = $signed(fir_out) >>> SHIFT;
    assign w_ext = EW'(w_sh);

`ifdef FIR_CTRL_SAT_EN
    localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EMAX = EW'($signed(OMAX));
    localparam logic signed [EW-1:0] EMIN = EW'($signed(OMIN));

    always_comb begin
        w_res = w_ext[OUT_W-1:0];
        if (w_ext > EMAX)      w_res = OMAX;
        else if (w_ext < EMIN) w_res = OMIN;
    end
`else
    assign w_res = w_ext[OUT_W-1:0];
`endif

    // Pacing, output stage and coefficient banks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_pending <= 1'b0;
            r_mvalid  <= 1'b0;
            r_mdata   <= '0;
            r_active  <= '0;
            for (int i = 0; i < TAPS; i++) r_shadow[i] <= '0;
        end else begin
            if (r_state == S_SWAP || w_fir_en)
                r_tick <= '0;
            else if (r_state == S_RUN && r_tick != TMAX)
                r_tick <= r_tick + TW'(1);

            if (w_fir_en) begin
                r_mvalid <= 1'b1;
                r_mdata  <= w_res;
            end else if (m_ready) begin
                r_mvalid <= 1'b0;
            end

            if (w_we_ok) r_shadow[cfg_addr] <= cfg_data;

            if (r_state == S_SWAP) begin
                for (int i = 0; i < TAPS; i++)
                    r_active[i*BIT_PREC +: BIT_PREC] <= r_shadow[i];
                r_pending <= 1'b0;
            end else if (cfg_commit && !w_busy) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign s_ready   = w_rdy;
    assign fir_en    = w_fir_en;
    assign fir_clr   = w_clr;
    assign cfg_busy  = w_busy;
    assign fir_in    = rst ? '0 : s_data;
    assign m_valid   = r_mvalid;
    assign m_data    = r_mdata;
    assign coef_flat = r_active;

endmodule
